// File: rtl/router_pkg.sv
// Shared definitions for the router egress path: scheduler states,
// header field positions and the round-robin port picker.
package router_pkg;

    localparam int NPORT    = 3;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        ABORT = 2'd3
    } sched_state_t;

    // Returns {found, port}: the first requesting port after 'last',
    // searching last+1, last+2, last+3 (mod NPORT).
    function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                           input logic [NPORT-1:0] req);
        logic [2:0] res;
        logic [1:0] p;
        res = 3'b000;
        // Walk the search order backwards so the nearest requester wins.
        for (int k = NPORT; k >= 1; k--) begin
            p = 2'((int'(last) + k) % NPORT);
            if (req[p]) begin
                res = {1'b1, p};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/egress_skid_buf.sv
// Two-entry tagged FIFO feeding the egress stream. The head entry drives
// the egress outputs directly; occupancy feeds the scheduler's read gate.
module egress_skid_buf #(
    parameter int W = 12
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop_ready,
    output logic [W-1:0] o_head,
    output logic         o_valid,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic         r_v0;
    logic         r_v1;
    logic         w_pop;

    assign w_pop   = r_v0 & i_pop_ready;
    assign o_head  = r_e0;
    assign o_valid = r_v0;
    assign o_occ   = {1'b0, r_v0} + {1'b0, r_v1};

    // Shift/fill the two entries; a simultaneous push and pop are both honoured.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_e0 <= '0;
            r_e1 <= '0;
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else if (w_pop) begin
            if (r_v1) begin
                r_e0 <= r_e1;
                if (i_push) begin
                    r_e1 <= i_push_data;
                end else begin
                    r_v1 <= 1'b0;
                end
            end else if (i_push) begin
                r_e0 <= i_push_data;
            end else begin
                r_v0 <= 1'b0;
            end
        end else if (i_push) begin
            if (!r_v0) begin
                r_e0 <= i_push_data;
                r_v0 <= 1'b1;
            end else if (!r_v1) begin
                r_e1 <= i_push_data;
                r_v1 <= 1'b1;
            end
        end
    end

    // The scheduler's read gate must never let a byte arrive with both entries full.
    always_ff @(posedge clock) begin
        if (resetn) begin
            assert (!(i_push && r_v0 && r_v1 && !w_pop));
        end
    end

endmodule

// File: rtl/router_egress_sched.sv
// Round-robin packet scheduler draining three router output channels onto
// one egress byte stream, one whole packet at a time, with sop/eop tags.
module router_egress_sched
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LEN_MSB = 7,
    parameter int RR_INIT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out_0,
    input  logic              vld_out_1,
    input  logic              vld_out_2,
    input  logic [DATA_W-1:0] data_out_0,
    input  logic [DATA_W-1:0] data_out_1,
    input  logic [DATA_W-1:0] data_out_2,
    output logic              read_enb_0,
    output logic              read_enb_1,
    output logic              read_enb_2,
    output logic [DATA_W-1:0] eg_data,
    output logic              eg_valid,
    input  logic              eg_ready,
    output logic              eg_sop,
    output logic              eg_eop,
    output logic [1:0]        eg_port,
    output logic              pkt_abort,
    output logic              sched_busy
);

    // to_read holds payload length + 1 (parity), so one bit wider than the field.
    localparam int TR_W = LEN_MSB - LEN_LSB + 2;
    localparam int BW   = DATA_W + 4;

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    logic [1:0]        r_rr;
    logic [1:0]        r_grant;
    logic [TR_W-1:0]   r_to_read;
    logic              r_inflight;
    logic              r_inflight_hdr;
    logic              r_inflight_eop;

    logic [NPORT-1:0]  w_vld;
    logic [NPORT-1:0]  w_rd_vec;
    logic [DATA_W-1:0] w_rdata;
    logic              w_vld_g;
    logic              w_room;
    logic              w_rd;
    logic [2:0]        w_pick;
    logic [1:0]        w_occ;
    logic [BW-1:0]     w_push_data;
    logic [BW-1:0]     w_head;

    assign w_vld  = {vld_out_2, vld_out_1, vld_out_0};
    assign w_pick = rr_pick(r_rr, w_vld);
    // Room counts a byte still in flight from the channel FIFO.
    assign w_room = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2;

    // Select the granted channel's valid flag and returned data.
    always_comb begin
        w_vld_g = 1'b0;
        w_rdata = '0;
        case (r_grant)
            2'd0: begin w_vld_g = vld_out_0; w_rdata = data_out_0; end
            2'd1: begin w_vld_g = vld_out_1; w_rdata = data_out_1; end
            2'd2: begin w_vld_g = vld_out_2; w_rdata = data_out_2; end
            default: begin w_vld_g = 1'b0; w_rdata = '0; end
        endcase
    end

    // Next-state and read-issue decision.
    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick[2]) begin
                    w_state_next = HDR;
                end
            end
            HDR: begin
                // Header in flight: its length is captured this cycle.
                if (r_inflight) begin
                    w_state_next = BODY;
                end else if (w_vld_g) begin
                    w_rd = w_room;
                end else begin
                    w_state_next = ABORT;
                end
            end
            BODY: begin
                if (r_inflight && r_inflight_eop) begin
                    w_state_next = IDLE;
                end else begin
                    w_rd = w_vld_g && (r_to_read != '0) && w_room;
                    if (!w_vld_g && (r_to_read != '0) && !r_inflight) begin
                        w_state_next = ABORT;
                    end
                end
            end
            ABORT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant pointer, remaining-read counter and in-flight tags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rr           <= 2'(RR_INIT);
            r_grant        <= 2'd0;
            r_to_read      <= '0;
            r_inflight     <= 1'b0;
            r_inflight_hdr <= 1'b0;
            r_inflight_eop <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_pick[2]) begin
                r_grant <= w_pick[1:0];
                r_rr    <= w_pick[1:0];
            end
            if ((r_state == HDR) && r_inflight) begin
                r_to_read <= TR_W'(w_rdata[LEN_MSB:LEN_LSB]) + TR_W'(1);
            end else if (w_rd) begin
                r_to_read <= r_to_read - TR_W'(1);
            end
            r_inflight     <= w_rd;
            r_inflight_hdr <= w_rd && (r_state == HDR);
            r_inflight_eop <= w_rd && (r_state == BODY) && (r_to_read == TR_W'(1));
        end
    end

    // One read strobe per port, only ever for the granted port.
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd
            assign w_rd_vec[gi] = w_rd && (r_grant == 2'(gi));
        end
    endgenerate

    assign read_enb_0 = w_rd_vec[0];
    assign read_enb_1 = w_rd_vec[1];
    assign read_enb_2 = w_rd_vec[2];

    assign w_push_data = {w_rdata, r_inflight_hdr, r_inflight_eop, r_grant};

    egress_skid_buf #(
        .W (BW)
    ) u_buf (
        .clock       (clock),
        .resetn      (resetn),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop_ready (eg_ready),
        .o_head      (w_head),
        .o_valid     (eg_valid),
        .o_occ       (w_occ)
    );

    assign eg_data    = w_head[BW-1:4];
    assign eg_sop     = w_head[3];
    assign eg_eop     = w_head[2];
    assign eg_port    = w_head[1:0];
    assign pkt_abort  = (r_state == ABORT);
    assign sched_busy = (r_state == HDR) || (r_state == BODY);

endmodule
